multiword_add_seq: RTL and testbench

//   Sequencer that adds two WORDS*WIDTH-bit operands by driving one WIDTH-bit

---
 rtl/multiword_add_seq_if.sv | 31 +++
 rtl/multiword_add_seq.sv | 115 +++++++++++
 tb/tb_multiword_add_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_if.sv
// rtl/multiword_add_seq_if.sv - operand/result handshakes and adder hookup for multiword_add_seq
// slave is the sequencer side; master is the environment (producer, consumer and chunk adder).
interface multiword_add_seq_if #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WORDS*WIDTH-1:0]   a;
  logic [WORDS*WIDTH-1:0]   b;
  logic                     cin;
  logic [WIDTH-1:0]         add_x;
  logic [WIDTH-1:0]         add_y;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_z;
  logic                     add_cout;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORDS*WIDTH-1:0]   sum;
  logic                     cout;

  modport slave (
    input  in_valid, a, b, cin, add_z, add_cout, out_ready,
    output in_ready, add_x, add_y, add_cin, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, add_z, add_cout, out_ready,
    input  in_ready, add_x, add_y, add_cin, out_valid, sum, cout
  );
endinterface

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - chunk-serial multiword add sequencer
// Feeds an external WIDTH-bit adder one chunk per cycle, least-significant first, carry registered.
module multiword_add_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int TOTAL = WORDS * WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [TOTAL-1:0]  a_q, a_d;
  logic [TOTAL-1:0]  b_q, b_d;
  logic [TOTAL-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  x_chunk, y_chunk;

  // Constant-index mux keeps the chunk select legal for any WORDS, including 1.
  always_comb begin
    x_chunk = '0;
    y_chunk = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_chunk = a_q[i*WIDTH +: WIDTH];
        y_chunk = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.add_x     = (state_q == RUN) ? x_chunk : '0;
  assign bus.add_y     = (state_q == RUN) ? y_chunk : '0;
  assign bus.add_cin   = (state_q == RUN) ? carry_q : 1'b0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*WIDTH +: WIDTH] = bus.add_z;
          end
        end
        carry_d = bus.add_cout;
        if (idx_q == LAST) begin
          cout_d  = bus.add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - self-checking bench for multiword_add_seq
// Vector table, hand-written corner sequences and a random back-to-back run against a 33-bit arithmetic model.
module tb_multiword_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.WIDTH(8), .WORDS(4)) if4 ();
  multiword_add_seq_if #(.WIDTH(8), .WORDS(1)) if1 ();

  multiword_add_seq #(.WIDTH(8), .WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  multiword_add_seq #(.WIDTH(8), .WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // The attached prefix adder is modelled as plain combinational addition.
  always_comb {if4.add_cout, if4.add_z} = {1'b0, if4.add_x} + {1'b0, if4.add_y} + {8'd0, if4.add_cin};
  always_comb {if1.add_cout, if1.add_z} = {1'b0, if1.add_x} + {1'b0, if1.add_y} + {8'd0, if1.add_cin};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic txn4(input string name, input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [31:0] es, input logic ec, input int exp_ones);
    int edges;
    int ones;
    if4.a = a;
    if4.b = b;
    if4.cin = cin;
    if4.in_valid = 1'b1;
    if4.out_ready = 1'b0;
    check({name, "_in_ready"}, 64'(if4.in_ready), 64'd1);
    tick;
    if4.in_valid = 1'b0;
    edges = 1;
    ones = 0;
    while (!if4.out_valid && edges < 40) begin
      if (if4.add_cin) ones++;
      tick;
      edges++;
    end
    check({name, "_latency"}, 64'(edges), 64'd5);
    check({name, "_sum"}, 64'(if4.sum), 64'(es));
    check({name, "_cout"}, 64'(if4.cout), 64'(ec));
    if (exp_ones >= 0) check({name, "_add_cin_ones"}, 64'(ones), 64'(exp_ones));
    if4.out_ready = 1'b1;
    tick;
    if4.out_ready = 1'b0;
    check({name, "_back_idle"}, 64'({if4.in_ready, if4.out_valid}), 64'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa[$];
    logic [31:0] pb[$];
    logic        pc[$];
    logic [32:0] exp_q[$];
    logic [32:0] model;
    logic [32:0] got;
    int          edges;
    int          cyc;
    int          last_acc;
    int          n_in;
    int          n_out;
    int          nv;
    int          stable_bad;
    bit          acc;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 32'h0000_0000, 1'b1};

    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_state4", 64'({if4.in_ready, if4.out_valid, if4.cout, if4.sum}), {29'd0, 3'b100, 32'd0});
    check("reset_state1", 64'({if1.in_ready, if1.out_valid, if1.cout, if1.sum}), {53'd0, 3'b100, 8'd0});
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      txn4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
           (i == 1) ? 4 : -1);
    end

    // Backpressure with stray in_valid pulses during RUN and DONE.
    if4.a = 32'h0F0F_0F0F; if4.b = 32'h0101_0101; if4.cin = 1'b1;
    if4.in_valid = 1'b1; if4.out_ready = 1'b0;
    tick;
    if4.in_valid = 1'b0;
    tick;
    if4.a = 32'hFFFF_FFFF; if4.b = 32'hFFFF_FFFF; if4.in_valid = 1'b1;
    check("bp_run_in_ready", 64'(if4.in_ready), 64'd0);
    tick;
    if4.in_valid = 1'b0;
    edges = 0;
    while (!if4.out_valid && edges < 40) begin
      tick;
      edges++;
    end
    check("bp_out_valid", 64'(if4.out_valid), 64'd1);
    stable_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if4.in_valid = (k == 3);
      if (if4.sum !== 32'h1010_1011 || if4.cout !== 1'b0 || if4.in_ready !== 1'b0 || if4.out_valid !== 1'b1)
        stable_bad++;
      tick;
    end
    if4.in_valid = 1'b0;
    check("bp_hold_bad_cycles", 64'(stable_bad), 64'd0);
    check("bp_sum", 64'(if4.sum), 64'h1010_1011);
    if4.out_ready = 1'b1;
    tick;
    if4.out_ready = 1'b0;
    check("bp_release", 64'({if4.in_ready, if4.out_valid}), 64'b10);
    tick;
    check("bp_no_stray_accept", 64'({if4.in_ready, if4.out_valid}), 64'b10);

    // Asynchronous reset in the middle of RUN.
    if4.a = 32'h1111_1111; if4.b = 32'h2222_2222; if4.cin = 1'b0; if4.in_valid = 1'b1;
    tick;
    if4.in_valid = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_run", 64'({if4.in_ready, if4.out_valid, if4.cout, if4.sum}), {29'd0, 3'b100, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    stable_bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) stable_bad++;
    end
    check("rst_abandoned", 64'(stable_bad), 64'd0);

    // WORDS=1 instance.
    if1.a = 8'h80; if1.b = 8'h80; if1.cin = 1'b1; if1.in_valid = 1'b1; if1.out_ready = 1'b0;
    tick;
    if1.in_valid = 1'b0;
    edges = 1;
    while (!if1.out_valid && edges < 20) begin
      tick;
      edges++;
    end
    check("w1_latency", 64'(edges), 64'd2);
    check("w1_sum_cout", 64'({if1.cout, if1.sum}), 64'h101);
    if1.out_ready = 1'b1;
    tick;
    if1.out_ready = 1'b0;
    check("w1_idle", 64'({if1.in_ready, if1.out_valid}), 64'b10);
    if1.a = 8'hFF; if1.b = 8'h00; if1.cin = 1'b0; if1.in_valid = 1'b1;
    tick;
    if1.in_valid = 1'b0;
    tick;
    check("w1_sum_ff", 64'({if1.out_valid, if1.cout, if1.sum}), 64'h2FF);
    if1.out_ready = 1'b1;
    tick;
    if1.out_ready = 1'b0;

    // Back-to-back stream: 3 fixed pairs then 1000 random pairs.
    pa.push_back(32'h0000_00FF); pb.push_back(32'h0000_0001); pc.push_back(1'b0);
    pa.push_back(32'hFFFF_FFFF); pb.push_back(32'h0000_0000); pc.push_back(1'b1);
    pa.push_back(32'hCAFE_F00D); pb.push_back(32'h3501_0FF3); pc.push_back(1'b1);
    for (int i = 0; i < 1000; i++) begin
      pa.push_back($urandom());
      pb.push_back($urandom());
      pc.push_back(1'($urandom_range(0, 1)));
    end
    nv = pa.size();
    n_in = 0; n_out = 0; cyc = 0; last_acc = -1;
    if4.a = pa[0]; if4.b = pb[0]; if4.cin = pc[0];
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    while (n_out < nv && cyc < nv * 6 + 100) begin
      acc = if4.in_valid && if4.in_ready;
      if (if4.out_valid) begin
        got = {if4.cout, if4.sum};
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_output", 64'(got), 64'h1_DEAD_DEAD);
        end else begin
          model = exp_q.pop_front();
          check($sformatf("b2b_result%0d", n_out), 64'(got), 64'(model));
        end
        n_out++;
      end
      if (acc) begin
        if (last_acc >= 0) check($sformatf("b2b_spacing%0d", n_in), 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
        model = {1'b0, if4.a} + {1'b0, if4.b} + {32'd0, if4.cin};
        exp_q.push_back(model);
      end
      tick;
      cyc++;
      if (acc) begin
        n_in++;
        if (n_in < nv) begin
          if4.a = pa[n_in]; if4.b = pb[n_in]; if4.cin = pc[n_in];
        end else begin
          if4.in_valid = 1'b0;
        end
      end
    end
    check("b2b_outputs_seen", 64'(n_out), 64'(nv));
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
